collision_matrix: RTL

- Parametrised frame-level collision detector for the game playfield.
- Takes per-pixel `drawing` flags from two sprite groups:
  - Group A: the player-side sprites, e.g. spaceship and bullets.
  - Group B: the target-side sprites, e.g. asteroids.
- Accumulates every A×B overlap over one video frame and publishes a registered per-pair hit matrix at the next `frame` strobe.
- Also produces rising-hit pulses and a saturating score counter.
- Sits between the sprite generators and the game-state logic; it replaces the ad-hoc per-frame collision registers at top level.

---
 rtl/collision_pkg.sv | 25 ++
 rtl/pair_accum.sv | 34 +++
 rtl/collision_matrix.sv | 134 +++++++++++++
 3 files changed

// File: rtl/collision_pkg.sv
// Shared limits and helpers for the frame-level collision matrix.
package collision_pkg;

    localparam int unsigned A_MAX = 8;
    localparam int unsigned B_MAX = 32;
    // Enough bits to hold a count of up to B_MAX set bits.
    localparam int unsigned POP_W = 6;

    // Flat bit position of pair (a,b) in the A x B matrix.
    function automatic int unsigned pair_idx(input int unsigned a, input int unsigned b,
                                             input int unsigned b_count);
        return a * b_count + b;
    endfunction

    // Number of set bits in a B_MAX-wide vector, returned POP_W wide.
    function automatic logic [POP_W-1:0] popcount_sat(input logic [B_MAX-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(B_MAX); i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/pair_accum.sv
// One A x B pair: per-frame overlap accumulator plus its published hit bit.
module pair_accum (
    input  logic clk_pix,
    input  logic reset_n,
    input  logic clear,
    input  logic frame,
    input  logic term,
    output logic acc,
    output logic hit
);

    logic acc_q;
    logic hit_q;

    // The frame-cycle pixel belongs to the new frame: it seeds acc, never the latch.
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= 1'b0;
            hit_q <= 1'b0;
        end else if (clear) begin
            acc_q <= 1'b0;
            hit_q <= 1'b0;
        end else if (frame) begin
            acc_q <= term;
            hit_q <= acc_q;
        end else begin
            acc_q <= acc_q | term;
        end
    end

    assign acc = acc_q;
    assign hit = hit_q;

endmodule

// File: rtl/collision_matrix.sv
// Frame-level A x B sprite collision detector with rising-hit score counter.
module collision_matrix
    import collision_pkg::*;
#(
    parameter int unsigned A_COUNT = 2,
    parameter int unsigned B_COUNT = 10,
    parameter int unsigned CNT_W   = 10
) (
    input  logic                         clk_pix,
    input  logic                         reset_n,
    input  logic                         frame,
    input  logic                         de,
    input  logic                         clear,
    input  logic [A_COUNT-1:0]           a_drawing,
    input  logic [B_COUNT-1:0]           b_drawing,
    input  logic [A_COUNT*B_COUNT-1:0]   pair_mask,
    output logic [A_COUNT*B_COUNT-1:0]   pair_hit,
    output logic [A_COUNT-1:0]           a_hit,
    output logic [B_COUNT-1:0]           b_hit,
    output logic                         any_hit,
    output logic [B_COUNT-1:0]           b_hit_rise,
    output logic                         hit_valid,
    output logic [CNT_W-1:0]             hit_total
);

    localparam int unsigned N = A_COUNT * B_COUNT;

    if (A_COUNT < 1 || A_COUNT > A_MAX) begin : g_bad_a
        $error("collision_matrix: A_COUNT out of range");
    end
    if (B_COUNT < 1 || B_COUNT > B_MAX) begin : g_bad_b
        $error("collision_matrix: B_COUNT out of range");
    end

    logic [N-1:0]           term;
    logic [N-1:0]           acc_vec;
    logic [A_COUNT-1:0]     a_next;
    logic [B_COUNT-1:0]     b_next;
    logic                   any_next;
    logic [B_COUNT-1:0]     rise_next;
    logic [B_MAX-1:0]       rise_pad;
    logic [POP_W-1:0]       rise_cnt;
    logic [CNT_W+POP_W-1:0] sum;
    logic [CNT_W-1:0]       total_next;

    logic [A_COUNT-1:0]     a_hit_q;
    logic [B_COUNT-1:0]     b_hit_q;
    logic                   any_hit_q;
    logic [B_COUNT-1:0]     b_hit_rise_q;
    logic                   hit_valid_q;
    logic [CNT_W-1:0]       hit_total_q;

    for (genvar a = 0; a < int'(A_COUNT); a++) begin : g_a
        for (genvar b = 0; b < int'(B_COUNT); b++) begin : g_b
            localparam int unsigned I = pair_idx(a, b, B_COUNT);

            assign term[I] = de & a_drawing[a] & b_drawing[b] & pair_mask[I];

            pair_accum u_pair (
                .clk_pix (clk_pix),
                .reset_n (reset_n),
                .clear   (clear),
                .frame   (frame),
                .term    (term[I]),
                .acc     (acc_vec[I]),
                .hit     (pair_hit[I])
            );
        end
    end

    // Reductions are taken from the accumulators, i.e. the pair_hit value about to be latched.
    always_comb begin
        a_next = '0;
        b_next = '0;
        for (int a = 0; a < int'(A_COUNT); a++) begin
            for (int b = 0; b < int'(B_COUNT); b++) begin
                a_next[a] = a_next[a] | acc_vec[a*int'(B_COUNT)+b];
                b_next[b] = b_next[b] | acc_vec[a*int'(B_COUNT)+b];
            end
        end
        any_next = |acc_vec;
    end

    // b_hit_q still holds the previous frame's b_hit here, so it serves as prev_b_hit.
    always_comb begin
        rise_next                = b_next & ~b_hit_q;
        rise_pad                 = '0;
        rise_pad[B_COUNT-1:0]    = rise_next;
        rise_cnt                 = popcount_sat(rise_pad);
        sum                      = {{POP_W{1'b0}}, hit_total_q} + {{CNT_W{1'b0}}, rise_cnt};
        if (sum > {{POP_W{1'b0}}, {CNT_W{1'b1}}}) begin
            total_next = {CNT_W{1'b1}};
        end else begin
            total_next = sum[CNT_W-1:0];
        end
    end

    // Publish reductions, rise pulses and score on a frame strobe; clear wins over frame.
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            a_hit_q      <= '0;
            b_hit_q      <= '0;
            any_hit_q    <= 1'b0;
            b_hit_rise_q <= '0;
            hit_valid_q  <= 1'b0;
            hit_total_q  <= '0;
        end else if (clear) begin
            a_hit_q      <= '0;
            b_hit_q      <= '0;
            any_hit_q    <= 1'b0;
            b_hit_rise_q <= '0;
            hit_valid_q  <= 1'b0;
            hit_total_q  <= '0;
        end else if (frame) begin
            a_hit_q      <= a_next;
            b_hit_q      <= b_next;
            any_hit_q    <= any_next;
            b_hit_rise_q <= rise_next;
            hit_valid_q  <= 1'b1;
            hit_total_q  <= total_next;
        end else begin
            b_hit_rise_q <= '0;
            hit_valid_q  <= 1'b0;
        end
    end

    assign a_hit      = a_hit_q;
    assign b_hit      = b_hit_q;
    assign any_hit    = any_hit_q;
    assign b_hit_rise = b_hit_rise_q;
    assign hit_valid  = hit_valid_q;
    assign hit_total  = hit_total_q;

endmodule
